jogo_genius_param: RTL and testbench
====================================

// Module: jogo_genius_param
// PURPOSE
//  Self-contained, parametrised Genius (Simon) game engine: control FSM, sequence memory, LFSR sequence
//  source, LED-display timer and per-play timeout in one block. Generalises the fixed 4-button game
//  top: N buttons, 2**LOG_RODADAS rounds, random or player-recorded sequences.
//  Sits between the board I/O (debounced one-hot buttons, LEDs) and the display/buzzer logic.
// PARAMETERS
//  N_BOTOES     4     number of buttons/LEDs (>=2); jogada index width W = $clog2(N_BOTOES)
//  LOG_RODADAS  4     rounds to win = 2**LOG_RODADAS; sequence memory depth = 2**LOG_RODADAS
//  TEMPO_LED    2500  cycles a LED stays lit (and then dark) per shown element
//  TIMEOUT      15000 cycles allowed per play in ESPERA before timeout loss
// PORTS
//  clock        in   1         system clock
//  reset        in   1         synchronous, active-high reset
//  iniciar      in   1         start/restart request (level, sampled in INICIAL and final states)
//  botoes       in   N_BOTOES  debounced buttons, one bit per button
//  modo         in   1         0: new element from LFSR; 1: player records new element; latched in PREPARA
//  leds         out  N_BOTOES  one-hot LED drive (shown element or echo of pressed button)
//  vez_jogador  out  1         high in ESPERA/GRAVA (player expected to press)
//  pronto       out  1         high in any final state
//  ganhou       out  1         high in FIM_GANHOU
//  perdeu       out  1         high in FIM_ERRO and FIM_TIMEOUT
//  timeout      out  1         high in FIM_TIMEOUT only
// BEHAVIOUR
//  - Reset: state=INICIAL; all outputs 0; rodada=0, endereco=0, timers=0; LFSR=16'hACE1 (never 0).
//  - LFSR: 16-bit Fibonacci (taps 16,14,13,11), steps every cycle; new element = lfsr mod N_BOTOES.
//  - Press detect: jogada_feita = 1-cycle pulse on (|botoes) rising edge (registered previous value).
//    Valid jogada = exactly one bit set; multiple bits at the edge count as a wrong play.
//  - FSM states / transitions:
//    INICIAL: iniciar -> PREPARA.
//    PREPARA (1 cycle): rodada=0, endereco=0, mem[0]=LFSR element (even if modo=1), latch modo -> MOSTRA_LED.
//    MOSTRA_LED: leds=onehot(mem[endereco]) for TEMPO_LED cycles -> MOSTRA_PAUSA.
//    MOSTRA_PAUSA: leds=0 for TEMPO_LED cycles; endereco==rodada -> endereco=0, ESPERA; else endereco++, MOSTRA_LED.
//    ESPERA: tempo counter runs; jogada_feita -> COMPARA; counter==TIMEOUT-1 with no press -> FIM_TIMEOUT.
//      Press and expiry in the same cycle: press wins.
//    COMPARA (1 cycle): wrong -> FIM_ERRO; correct & endereco<rodada -> endereco++, ESPERA;
//      correct & endereco==rodada: rodada==2**LOG_RODADAS-1 -> FIM_GANHOU; else PROX_RODADA.
//    PROX_RODADA (1 cycle): rodada++; modo=0 -> mem[rodada+1]=LFSR element, endereco=0, MOSTRA_LED;
//      modo=1 -> GRAVA.
//    GRAVA: vez_jogador=1, no timeout; valid press -> mem[rodada]=index, endereco=0, MOSTRA_LED;
//      multi-bit press ignored (stay).
//    FIM_GANHOU / FIM_ERRO / FIM_TIMEOUT: outputs held; iniciar -> PREPARA (new game, LFSR not reseeded).
//  - In ESPERA/GRAVA leds echo botoes while held. Tempo counter clears on every ESPERA entry
//    and on every press.
//  - Round r (0-based) shows and checks r+1 elements; endereco/rodada are LOG_RODADAS bits, never wrap.
//  - reset mid-game: returns to INICIAL next edge, memory contents don't care.
//  - iniciar ignored outside INICIAL and final states.
// CONFIGURATION
//  GENIUS_DEBUG_EN defined: adds outputs db_estado[3:0] (state code, INICIAL=0 ... FIM_TIMEOUT=10 in listed
//  order), db_rodada[LOG_RODADAS-1:0], db_endereco[LOG_RODADAS-1:0], db_jogada_correta (COMPARA result).
//  Undefined: those ports and their logic absent; functional behaviour identical.
// TESTING (N_BOTOES=4, LOG_RODADAS=2, TEMPO_LED=4, TIMEOUT=20)
//  - Reset then iniciar=1 one cycle -> PREPARA, 4 cycles one-hot LED, 4 dark, vez_jogador=1.
//  - modo=0, replay shown sequence each round -> 4 rounds shown 1,2,3,4 elements; ganhou=pronto=1, others 0.
//  - Round 0, press a button different from the shown LED -> perdeu=1, pronto=1, timeout=0, ganhou=0.
//  - In ESPERA hold botoes=0 for 20 cycles -> FIM_TIMEOUT: perdeu=timeout=pronto=1; press on cycle 20 -> no timeout.
//  - modo=1, after round 0 press 4'b0100 in GRAVA -> round 1 shows mem[0] then LED 4'b0100;
//    4'b0110 in GRAVA ignored.
//  - botoes=4'b0011 in ESPERA -> FIM_ERRO; reset asserted in MOSTRA_LED -> next cycle all outputs 0, INICIAL.

Source files
------------

// File: rtl/jogo_genius_param_if.sv
// Board-side signal bundle for the Genius game engine: start/mode/buttons in, LEDs and status flags out.
interface jogo_genius_param_if #(
   parameter int unsigned N_BOTOES = 4
) ();
   logic                iniciar;
   logic [N_BOTOES-1:0] botoes;
   logic                modo;
   logic [N_BOTOES-1:0] leds;
   logic                vez_jogador;
   logic                pronto;
   logic                ganhou;
   logic                perdeu;
   logic                timeout;

   modport master (
      output iniciar, botoes, modo,
      input  leds, vez_jogador, pronto, ganhou, perdeu, timeout
   );

   modport slave (
      input  iniciar, botoes, modo,
      output leds, vez_jogador, pronto, ganhou, perdeu, timeout
   );
endinterface

// File: rtl/jogo_genius_param.sv
// Parametrised Genius (Simon) engine: FSM, sequence memory, LFSR source, LED timer and play timeout.
// Define GENIUS_DEBUG_EN to expose db_estado/db_rodada/db_endereco/db_jogada_correta.
module jogo_genius_param #(
   parameter int unsigned N_BOTOES    = 4,
   parameter int unsigned LOG_RODADAS = 4,
   parameter int unsigned TEMPO_LED   = 2500,
   parameter int unsigned TIMEOUT     = 15000
) (
   input  logic                   clock,
   input  logic                   reset,
   jogo_genius_param_if.slave     io
`ifdef GENIUS_DEBUG_EN
   ,
   output logic [3:0]             db_estado,
   output logic [LOG_RODADAS-1:0] db_rodada,
   output logic [LOG_RODADAS-1:0] db_endereco,
   output logic                   db_jogada_correta
`endif
);

   localparam int unsigned W     = $clog2(N_BOTOES);
   localparam int unsigned LR    = LOG_RODADAS;
   localparam int unsigned DEPTH = 2 ** LOG_RODADAS;
   localparam int unsigned TMAX  = (TEMPO_LED > TIMEOUT) ? TEMPO_LED : TIMEOUT;
   localparam int unsigned CW    = $clog2(TMAX + 1);

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      PREPARA      = 4'd1,
      MOSTRA_LED   = 4'd2,
      MOSTRA_PAUSA = 4'd3,
      ESPERA       = 4'd4,
      COMPARA      = 4'd5,
      PROX_RODADA  = 4'd6,
      GRAVA        = 4'd7,
      FIM_GANHOU   = 4'd8,
      FIM_ERRO     = 4'd9,
      FIM_TIMEOUT  = 4'd10
   } estado_t;

   estado_t         state_q, state_d;
   logic [15:0]     lfsr_q;
   logic [LR-1:0]   rodada_q, endereco_q;
   logic [CW-1:0]   cnt_q;
   logic            algum_q;
   logic            jogada_ok_q;
   logic            modo_q;
   logic [W-1:0]    mem [DEPTH];

   logic            jogada_feita;
   logic            jogada_valida;
   logic [W-1:0]    jogada_idx;
   logic [W-1:0]    elemento;
   logic            tempo_led_fim;

   assign jogada_feita  = (|io.botoes) & ~algum_q;
   assign jogada_valida = $onehot(io.botoes);
   assign elemento      = W'(lfsr_q % 16'(N_BOTOES));
   assign tempo_led_fim = (cnt_q == CW'(TEMPO_LED - 1));

   // One-hot button vector to element index
   always_comb begin
      jogada_idx = '0;
      for (int i = 0; i < int'(N_BOTOES); i++) begin
         if (io.botoes[i]) jogada_idx = W'(i);
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= INICIAL;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         INICIAL:      if (io.iniciar) state_d = PREPARA;
         PREPARA:      state_d = MOSTRA_LED;
         MOSTRA_LED:   if (tempo_led_fim) state_d = MOSTRA_PAUSA;
         MOSTRA_PAUSA: if (tempo_led_fim) state_d = (endereco_q == rodada_q) ? ESPERA : MOSTRA_LED;
         ESPERA: begin
            if (jogada_feita)                       state_d = COMPARA;
            else if (cnt_q == CW'(TIMEOUT - 1))     state_d = FIM_TIMEOUT;
         end
         COMPARA: begin
            if (!jogada_ok_q)                state_d = FIM_ERRO;
            else if (endereco_q < rodada_q)  state_d = ESPERA;
            else if (rodada_q == '1)         state_d = FIM_GANHOU;
            else                             state_d = PROX_RODADA;
         end
         PROX_RODADA:  state_d = modo_q ? GRAVA : MOSTRA_LED;
         GRAVA:        if (jogada_feita && jogada_valida) state_d = MOSTRA_LED;
         FIM_GANHOU, FIM_ERRO, FIM_TIMEOUT: if (io.iniciar) state_d = PREPARA;
         default:      state_d = INICIAL;
      endcase
   end

   // Moore outputs; during the player's turn the LEDs echo the held buttons
   always_comb begin
      io.leds        = '0;
      io.vez_jogador = 1'b0;
      io.pronto      = 1'b0;
      io.ganhou      = 1'b0;
      io.perdeu      = 1'b0;
      io.timeout     = 1'b0;
      case (state_q)
         MOSTRA_LED:    io.leds = N_BOTOES'(1) << mem[endereco_q];
         ESPERA, GRAVA: begin
            io.vez_jogador = 1'b1;
            io.leds        = io.botoes;
         end
         FIM_GANHOU: begin
            io.pronto = 1'b1;
            io.ganhou = 1'b1;
         end
         FIM_ERRO: begin
            io.pronto = 1'b1;
            io.perdeu = 1'b1;
         end
         FIM_TIMEOUT: begin
            io.pronto  = 1'b1;
            io.perdeu  = 1'b1;
            io.timeout = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: LFSR, timer (cleared on every state change), round/address and sequence memory
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q      <= 16'hACE1;
         rodada_q    <= '0;
         endereco_q  <= '0;
         cnt_q       <= '0;
         algum_q     <= 1'b0;
         jogada_ok_q <= 1'b0;
         modo_q      <= 1'b0;
      end else begin
         lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         algum_q <= |io.botoes;
         cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
         case (state_q)
            PREPARA: begin
               rodada_q   <= '0;
               endereco_q <= '0;
               mem[0]     <= elemento;
               modo_q     <= io.modo;
            end
            MOSTRA_PAUSA: begin
               if (state_d != MOSTRA_PAUSA)
                  endereco_q <= (endereco_q == rodada_q) ? '0 : endereco_q + LR'(1);
            end
            ESPERA: begin
               if (jogada_feita)
                  jogada_ok_q <= jogada_valida && (jogada_idx == mem[endereco_q]);
            end
            COMPARA: begin
               if (state_d == ESPERA) endereco_q <= endereco_q + LR'(1);
            end
            PROX_RODADA: begin
               rodada_q <= rodada_q + LR'(1);
               if (!modo_q) begin
                  mem[rodada_q + LR'(1)] <= elemento;
                  endereco_q             <= '0;
               end
            end
            GRAVA: begin
               if (state_d == MOSTRA_LED) begin
                  mem[rodada_q] <= jogada_idx;
                  endereco_q    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef GENIUS_DEBUG_EN
   assign db_estado         = state_q;
   assign db_rodada         = rodada_q;
   assign db_endereco       = endereco_q;
   assign db_jogada_correta = jogada_ok_q;
`endif

endmodule

// File: tb/tb_jogo_genius_param.sv
// Directed bench for jogo_genius_param (N=4, 4 rounds, TEMPO_LED=4, TIMEOUT=20); LFSR elements come from a local model.
module tb_jogo_genius_param;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   jogo_genius_param_if #(.N_BOTOES(4)) io ();

`ifdef GENIUS_DEBUG_EN
   logic [3:0] db_estado;
   logic [1:0] db_rodada;
   logic [1:0] db_endereco;
   logic       db_jogada_correta;
`endif

   jogo_genius_param #(
      .N_BOTOES(4), .LOG_RODADAS(2), .TEMPO_LED(4), .TIMEOUT(20)
   ) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
`ifdef GENIUS_DEBUG_EN
      ,
      .db_estado         (db_estado),
      .db_rodada         (db_rodada),
      .db_endereco       (db_endereco),
      .db_jogada_correta (db_jogada_correta)
`endif
   );

   // Reference 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1
   logic [15:0] m;
   always @(posedge clock) begin
      if (reset) m <= 16'hACE1;
      else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
   end

   int checks = 0;
   int passed = 0;
   int failed = 0;
   logic [1:0] seq [4];

   function automatic logic [3:0] oh(input logic [1:0] v);
      logic [3:0] one;
      one = 4'b0001;
      return one << v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [3:0] l, input logic v, input logic p,
                           input logic g, input logic pe, input logic t);
      logic [8:0] got, exp;
      got = {io.leds, io.vez_jogador, io.pronto, io.ganhou, io.perdeu, io.timeout};
      exp = {l, v, p, g, pe, t};
      checks++;
      assert (got === exp) passed = passed + 1;
      else begin
         failed++;
         $error("FAIL %s: observed %b expected %b (leds,vez,pronto,ganhou,perdeu,timeout)", tag, got, exp);
      end
   endtask

   // Shows elements 0..r: 4 lit cycles then 4 dark each; ends in the first ESPERA cycle
   task automatic show_round(input int r);
      for (int i = 0; i <= r; i++) begin
         for (int c = 0; c < 4; c++) begin
            chk_outs("show_led", oh(seq[i]), 0, 0, 0, 0, 0);
            tick();
         end
         for (int c = 0; c < 4; c++) begin
            chk_outs("show_dark", 4'b0000, 0, 0, 0, 0, 0);
            tick();
         end
      end
   endtask

   // Replays elements 0..r correctly; ends one cycle after the final COMPARA
   task automatic play(input int r);
      for (int i = 0; i <= r; i++) begin
         chk_outs("espera", 4'b0000, 1, 0, 0, 0, 0);
         io.botoes = oh(seq[i]);
         #1;
         chk_outs("echo", oh(seq[i]), 1, 0, 0, 0, 0);
         tick();
         io.botoes = 4'b0000;
         tick();
      end
   endtask

   task automatic start_game();
      io.iniciar = 1'b1;
      tick();
      io.iniciar = 1'b0;
      seq[0] = m[1:0];
      chk_outs("prepara", 4'b0000, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      io.iniciar = 1'b0;
      io.botoes  = 4'b0000;
      io.modo    = 1'b0;
      tick();
      tick();
      chk_outs("reset", 4'b0000, 0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();
      chk_outs("idle", 4'b0000, 0, 0, 0, 0, 0);

      // Full win with LFSR sequence
      start_game();
      for (int r = 0; r < 4; r++) begin
         show_round(r);
         play(r);
         if (r < 3) begin
            seq[r+1] = m[1:0];
            chk_outs("prox_rodada", 4'b0000, 0, 0, 0, 0, 0);
            tick();
         end
      end
      chk_outs("ganhou", 4'b0000, 0, 1, 1, 0, 0);
      tick();
      chk_outs("ganhou_hold", 4'b0000, 0, 1, 1, 0, 0);

      // Wrong button in round 0
      start_game();
      show_round(0);
      io.botoes = oh(seq[0] + 2'd1);
      tick();
      io.botoes = 4'b0000;
      tick();
      chk_outs("erro_wrong", 4'b0000, 0, 1, 0, 1, 0);

      // Timeout after 20 idle cycles
      start_game();
      show_round(0);
      for (int k = 0; k < 19; k++) tick();
      chk_outs("pre_timeout", 4'b0000, 1, 0, 0, 0, 0);
      tick();
      chk_outs("timeout", 4'b0000, 0, 1, 0, 1, 1);

      // Press on the 20th cycle wins over expiry; then multi-bit press loses
      start_game();
      show_round(0);
      for (int k = 0; k < 19; k++) tick();
      io.botoes = oh(seq[0]);
      tick();
      chk_outs("press_wins", 4'b0000, 0, 0, 0, 0, 0);
      io.botoes = 4'b0000;
      tick();
      seq[1] = m[1:0];
      tick();
      show_round(1);
      io.botoes = 4'b0011;
      tick();
      io.botoes = 4'b0000;
      tick();
      chk_outs("erro_multi", 4'b0000, 0, 1, 0, 1, 0);

      // Player-recorded mode
      io.modo = 1'b1;
      start_game();
      io.modo = 1'b0;
      show_round(0);
      play(0);
      chk_outs("prox_gravar", 4'b0000, 0, 0, 0, 0, 0);
      tick();
      chk_outs("grava", 4'b0000, 1, 0, 0, 0, 0);
      io.botoes = 4'b0110;
      #1;
      chk_outs("grava_multi_echo", 4'b0110, 1, 0, 0, 0, 0);
      tick();
      chk_outs("grava_multi_stay", 4'b0110, 1, 0, 0, 0, 0);
      io.botoes = 4'b0000;
      tick();
      chk_outs("grava_idle", 4'b0000, 1, 0, 0, 0, 0);
      io.botoes = 4'b0100;
      tick();
      io.botoes = 4'b0000;
      seq[1] = 2'd2;
      show_round(1);
      play(1);
      tick();
      for (int k = 0; k < 25; k++) tick();
      chk_outs("grava_no_timeout", 4'b0000, 1, 0, 0, 0, 0);
      io.botoes = 4'b0001;
      tick();
      io.botoes = 4'b0000;
      chk_outs("mostra_pre_reset", oh(seq[0]), 0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      chk_outs("reset_mid", 4'b0000, 0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();
      chk_outs("idle_after_reset", 4'b0000, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
